board_mode_sequencer: RTL and testbench



---
 rtl/board_pkg.sv | 21 ++
 rtl/board_mode_sequencer_btn_debouncer.sv | 44 ++++
 rtl/board_mode_sequencer.sv | 114 +++++++++++
 tb/tb_board_mode_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared state codes, display constants and arithmetic helper for the board
// mode sequencer.
package board_pkg;

    typedef logic [1:0] state_t;

    // State codes equal the mode select codes on switches[9:8].
    localparam state_t S_PASS  = 2'b00;
    localparam state_t S_XOR   = 2'b01;
    localparam state_t S_ADD   = 2'b10;
    localparam state_t S_COUNT = 2'b11;

    localparam logic [3:0] ANODE_RIGHT = 4'b1110;
    localparam logic [3:0] ANODE_OFF   = 4'b1111;
    localparam logic [3:0] COUNT_START = 4'hF;

    function automatic logic [4:0] add_nibbles(input logic [3:0] a, input logic [3:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/board_mode_sequencer_btn_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stability debounce and a
// single-cycle pulse on each accepted press.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          btn_meta;
    logic          btn_sync;
    logic          btn_level;
    logic [CW-1:0] stable_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta   <= 1'b0;
            btn_sync   <= 1'b0;
            btn_level  <= 1'b0;
            stable_cnt <= '0;
            btn_pulse  <= 1'b0;
        end else begin
            btn_meta  <= btn_raw;
            btn_sync  <= btn_meta;
            btn_pulse <= 1'b0;
            // Counting only while the synced level disagrees makes any bounce restart the window.
            if (btn_sync == btn_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_cnt <= '0;
                btn_level  <= btn_sync;
                btn_pulse  <= btn_sync;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/board_mode_sequencer.sv
// Board top-level: synchronizes switches, picks one of four operating modes and
// drives the hex digit value, LEDs and anode enables from a registered FSM.
module board_mode_sequencer
    import board_pkg::*;
#(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] switches,
    input  logic       btn_center,
    output logic [3:0] value,
    output logic [3:0] led,
    output logic [3:0] anodes,
    output logic [1:0] mode
);

    localparam int TW = $clog2(TICK_DIV);

    logic [9:0]    sw_meta;
    logic [9:0]    sw_sync;
    logic          btn_pulse;
    state_t        state;
    logic [3:0]    countdown;
    logic          run;
    logic [TW-1:0] tick_cnt;

    logic [3:0] sw_a;
    logic [3:0] sw_b;
    state_t     sw_mode;
    logic [4:0] sum;

    assign sw_a    = sw_sync[3:0];
    assign sw_b    = sw_sync[7:4];
    assign sw_mode = sw_sync[9:8];
    assign sum     = add_nibbles(sw_a, sw_b);
    assign mode    = state;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_center),
        .btn_pulse(btn_pulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_PASS;
            value     <= 4'h0;
            led       <= 4'h0;
            anodes    <= ANODE_OFF;
            countdown <= COUNT_START;
            run       <= 1'b1;
            tick_cnt  <= '0;
        end else begin
            anodes <= ANODE_RIGHT;
            if (sw_mode != state) begin
                // Entry actions; a button pulse arriving with a mode change is dropped here.
                state <= sw_mode;
                case (sw_mode)
                    S_PASS: begin value <= sw_a; led <= 4'h0;        end
                    S_XOR:  begin value <= 4'h0; led <= sw_a ^ sw_b; end
                    S_ADD:  begin value <= 4'h0; led <= 4'h0;        end
                    default: begin
                        countdown <= COUNT_START;
                        value     <= COUNT_START;
                        tick_cnt  <= '0;
                        run       <= 1'b1;
                        led       <= 4'h0;
                    end
                endcase
            end else begin
                case (state)
                    S_PASS: begin value <= sw_a; led <= 4'h0;        end
                    S_XOR:  begin value <= 4'h0; led <= sw_a ^ sw_b; end
                    S_ADD: begin
                        if (btn_pulse) begin
                            value <= sum[3:0];
                            led   <= {3'b000, sum[4]};
                        end
                    end
                    default: begin
                        // A press wins over a coincident tick; the tick count is held either way.
                        if (btn_pulse) begin
                            run <= ~run;
                        end else if (run) begin
                            if (tick_cnt == TW'(TICK_DIV - 1)) begin
                                tick_cnt  <= '0;
                                countdown <= countdown - 4'd1;
                                value     <= countdown - 4'd1;
                            end else begin
                                tick_cnt <= tick_cnt + TW'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_mode_sequencer.sv
// Directed self-checking bench for board_mode_sequencer (TICK_DIV=4, DEBOUNCE_CYCLES=3).
module tb_board_mode_sequencer;

    logic       clk;
    logic       reset;
    logic [9:0] switches;
    logic       btn_center;
    logic [3:0] value;
    logic [3:0] led;
    logic [3:0] anodes;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    board_mode_sequencer #(
        .TICK_DIV       (4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .switches  (switches),
        .btn_center(btn_center),
        .value     (value),
        .led       (led),
        .anodes    (anodes),
        .mode      (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit before sampling or driving.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_outputs(input string name, input logic [3:0] v, input logic [3:0] l,
                                  input logic [3:0] an, input logic [1:0] m);
        n_checks++;
        if (value !== v || led !== l || anodes !== an || mode !== m) begin
            n_fail++;
            $display("FAIL %s: value=%h led=%b anodes=%b mode=%b, expected value=%h led=%b anodes=%b mode=%b",
                     name, value, led, anodes, mode, v, l, an, m);
        end
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        switches   = 10'h000;
        btn_center = 1'b0;
        step(3);
        expect_outputs("reset_hold", 4'h0, 4'h0, 4'b1111, 2'b00);
        reset = 1'b0;
        step(1);
        expect_outputs("reset_release", 4'h0, 4'h0, 4'b1110, 2'b00);
    endtask

    task automatic test_pass_xor;
        switches = {2'b00, 4'h0, 4'hA};
        step(2);
        expect_outputs("pass_latency_early", 4'h0, 4'h0, 4'b1110, 2'b00);
        step(1);
        expect_outputs("pass_latency_3", 4'hA, 4'h0, 4'b1110, 2'b00);
        switches = {2'b01, 4'h3, 4'h5};
        step(3);
        expect_outputs("xor_entry", 4'h0, 4'h6, 4'b1110, 2'b01);
        step(3);
        expect_outputs("xor_steady", 4'h0, 4'h6, 4'b1110, 2'b01);
    endtask

    task automatic test_add;
        switches = {2'b10, 4'h8, 4'h9};
        step(3);
        expect_outputs("add_entry", 4'h0, 4'h0, 4'b1110, 2'b10);
        step(2);
        btn_center = 1'b1;
        step(5);
        btn_center = 1'b0;
        expect_outputs("add_before_pulse", 4'h0, 4'h0, 4'b1110, 2'b10);
        step(1);
        expect_outputs("add_carry", 4'h1, 4'h1, 4'b1110, 2'b10);
        switches = {2'b10, 4'h8, 4'h2};
        step(8);
        expect_outputs("add_hold_on_switch", 4'h1, 4'h1, 4'b1110, 2'b10);
        btn_center = 1'b1;
        step(2);
        btn_center = 1'b0;
        step(10);
        expect_outputs("add_glitch_ignored", 4'h1, 4'h1, 4'b1110, 2'b10);
    endtask

    task automatic test_count_steps;
        logic [3:0] exp_v;
        switches = {2'b11, 4'h8, 4'h2};
        step(3);
        expect_outputs("count_entry", 4'hF, 4'h0, 4'b1110, 2'b11);
        step(3);
        expect_outputs("count_entry_hold", 4'hF, 4'h0, 4'b1110, 2'b11);
        step(1);
        exp_v = 4'hF;
        // Each tick decrements; the 16th tick wraps 0 back to F.
        for (int i = 1; i <= 16; i++) begin
            exp_v = exp_v - 4'd1;
            if (i > 1) step(4);
            n_checks++;
            if (value !== exp_v) begin
                n_fail++;
                $display("FAIL count_step_%0d: value=%h expected %h", i, value, exp_v);
            end
        end
    endtask

    task automatic test_count_pause;
        step(28);
        expect_outputs("count_at_8", 4'h8, 4'h0, 4'b1110, 2'b11);
        step(1);
        btn_center = 1'b1;
        step(5);
        btn_center = 1'b0;
        step(1);
        expect_outputs("pause_at_7", 4'h7, 4'h0, 4'b1110, 2'b11);
        for (int i = 0; i < 40; i++) begin
            step(1);
            n_checks++;
            if (value !== 4'h7) begin
                n_fail++;
                $display("FAIL pause_hold_%0d: value=%h expected 7", i, value);
            end
        end
        btn_center = 1'b1;
        step(5);
        btn_center = 1'b0;
        step(2);
        expect_outputs("resume_remaining", 4'h7, 4'h0, 4'b1110, 2'b11);
        step(1);
        expect_outputs("resume_to_6", 4'h6, 4'h0, 4'b1110, 2'b11);
        step(2);
        btn_center = 1'b1;
        step(5);
        btn_center = 1'b0;
        expect_outputs("pre_coincide_5", 4'h5, 4'h0, 4'b1110, 2'b11);
        step(1);
        expect_outputs("coincide_no_dec", 4'h5, 4'h0, 4'b1110, 2'b11);
        step(8);
        expect_outputs("coincide_paused", 4'h5, 4'h0, 4'b1110, 2'b11);
    endtask

    task automatic test_reset_mid_count;
        btn_center = 1'b1;
        step(5);
        btn_center = 1'b0;
        step(2);
        expect_outputs("resume_tick_4", 4'h4, 4'h0, 4'b1110, 2'b11);
        step(4);
        expect_outputs("count_at_3", 4'h3, 4'h0, 4'b1110, 2'b11);
        reset = 1'b1;
        #1;
        expect_outputs("async_reset", 4'h0, 4'h0, 4'b1111, 2'b00);
        step(2);
        reset = 1'b0;
        step(1);
        expect_outputs("rerelease_anodes", 4'h0, 4'h0, 4'b1110, 2'b00);
        step(1);
        expect_outputs("rerelease_sync", 4'h0, 4'h0, 4'b1110, 2'b00);
        // Mode select reaches the FSM through the 2-flop synchronizer, then enters S_COUNT.
        step(1);
        expect_outputs("rerelease_count_entry", 4'hF, 4'h0, 4'b1110, 2'b11);
    endtask

    initial begin
        test_reset();
        test_pass_xor();
        test_add();
        test_count_steps();
        test_count_pause();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
